// File: rtl/qlf_pipe_alu.sv
// qlf_pipe_alu: carry-segmented pipelined adder producing A+BB+ci and A^BB with valid/ready flow control.
// Define QLF_PIPE_ALU_SAT_EN to saturate y on overflow.
module qlf_pipe_alu #(
  parameter int WIDTH     = 32,
  parameter int SEG_WIDTH = 8,
  parameter bit SIGNED    = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] x,
  output logic             co,
  output logic             ovf
);
  localparam int STAGES = (WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;
  localparam int L = STAGES - 1;
  localparam int M = WIDTH - 1;
  logic             adv, ovf_d, ovf_q;
  logic [WIDTH-1:0] y_d;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  for (genvar k = 0; k < STAGES; k++) begin : g
    localparam int LO = k * SEG_WIDTH;
    localparam int W  = (k == L) ? WIDTH - LO : SEG_WIDTH;
    logic [WIDTH-1:0] a_i, bb_i, s_i, a_d, a_q, bb_d, bb_q, s_d, s_q;
    logic             c_i, v_i, c_d, c_q, v_d, v_q;
    logic [W:0]       seg;
`ifdef QLF_PIPE_ALU_SAT_EN
    logic             bi_i, bi_q;
`endif
    if (k == 0) begin : src
      assign a_i  = a;
      assign bb_i = bi ? ~b : b;
      assign s_i  = '0;
      assign c_i  = ci;
      assign v_i  = in_valid;
`ifdef QLF_PIPE_ALU_SAT_EN
      assign bi_i = bi;
`endif
    end else begin : src
      assign a_i  = g[k-1].a_q;
      assign bb_i = g[k-1].bb_q;
      assign s_i  = g[k-1].s_q;
      assign c_i  = g[k-1].c_q;
      assign v_i  = g[k-1].v_q;
`ifdef QLF_PIPE_ALU_SAT_EN
      assign bi_i = g[k-1].bi_q;
`endif
    end
    // Full operands ride along so the final stage can form x and the MSB carry-in.
    always_comb begin
      seg = {1'b0, a_i[LO+:W]} + {1'b0, bb_i[LO+:W]} + {{W{1'b0}}, c_i};
      s_d = s_i;
      s_d[LO+:W] = seg[W-1:0];
      a_d  = a_i;
      bb_d = bb_i;
      c_d  = seg[W];
      v_d  = v_i;
    end
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        a_q  <= '0;
        bb_q <= '0;
        s_q  <= '0;
        c_q  <= 1'b0;
        v_q  <= 1'b0;
`ifdef QLF_PIPE_ALU_SAT_EN
        bi_q <= 1'b0;
`endif
      end else if (adv) begin
        a_q  <= a_d;
        bb_q <= bb_d;
        s_q  <= (k == L) ? y_d : s_d;
        c_q  <= c_d;
        v_q  <= v_d;
`ifdef QLF_PIPE_ALU_SAT_EN
        bi_q <= bi_i;
`endif
      end
    end
  end
  always_comb begin
    ovf_d = SIGNED ? g[L].c_d ^ g[L].s_d[M] ^ g[L].a_i[M] ^ g[L].bb_i[M] : g[L].c_d;
    y_d   = g[L].s_d;
`ifdef QLF_PIPE_ALU_SAT_EN
    if (ovf_d)
      y_d = SIGNED ? (g[L].a_i[M] ? WIDTH'(1) << M : ~(WIDTH'(1) << M)) : {WIDTH{~g[L].bi_i}};
`endif
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ovf_q <= 1'b0;
    else if (adv) ovf_q <= ovf_d;
  end
  assign out_valid = g[L].v_q;
  assign y         = g[L].s_q;
  assign x         = g[L].a_q ^ g[L].bb_q;
  assign co        = g[L].c_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_qlf_pipe_alu.sv
// tb_qlf_pipe_alu: directed vector table plus randomized traffic checked against an arithmetic reference model.
module tb_qlf_pipe_alu;
  typedef struct packed {logic [15:0] y, x; logic co, ovf;} res_t;
  typedef struct {logic [15:0] a, b; bit ci, bi; logic [15:0] yu, ys, x; bit co, ovs;} vec_t;
  logic clk = 0, reset_n = 0, in_valid = 0, out_ready = 1, ci = 0, bi = 0;
  logic [15:0] a = 0, b = 0;
  logic [15:0] y0, x0, y1, x1;
  logic [9:0]  y2, x2;
  logic ir0, ir1, ir2, ov0, ov1, ov2, co0, co1, co2, of0, of1, of2;
  logic [15:0] y_o[3], x_o[3];
  logic co_o[3], of_o[3], ov_o[3], ir_o[3];
  int compared = 0, mismatched = 0;
  int delivered[3] = '{0, 0, 0};
  res_t sb[3][$];
  res_t hold_r[3];
  bit held[3] = '{0, 0, 0};
  bit done = 0;
  vec_t vt[7];

  always #5 clk = ~clk;

  qlf_pipe_alu #(.WIDTH(16), .SEG_WIDTH(4), .SIGNED(1'b0)) u0 (.clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(ir0), .a(a), .b(b), .ci(ci), .bi(bi), .out_valid(ov0),
    .out_ready(out_ready), .y(y0), .x(x0), .co(co0), .ovf(of0));
  qlf_pipe_alu #(.WIDTH(16), .SEG_WIDTH(4), .SIGNED(1'b1)) u1 (.clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(ir1), .a(a), .b(b), .ci(ci), .bi(bi), .out_valid(ov1),
    .out_ready(out_ready), .y(y1), .x(x1), .co(co1), .ovf(of1));
  qlf_pipe_alu #(.WIDTH(10), .SEG_WIDTH(4), .SIGNED(1'b0)) u2 (.clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(ir2), .a(a[9:0]), .b(b[9:0]), .ci(ci), .bi(bi), .out_valid(ov2),
    .out_ready(out_ready), .y(y2), .x(x2), .co(co2), .ovf(of2));

  always_comb begin
    y_o[0] = y0; y_o[1] = y1; y_o[2] = {6'd0, y2};
    x_o[0] = x0; x_o[1] = x1; x_o[2] = {6'd0, x2};
    co_o[0] = co0; co_o[1] = co1; co_o[2] = co2;
    of_o[0] = of0; of_o[1] = of1; of_o[2] = of2;
    ov_o[0] = ov0; ov_o[1] = ov1; ov_o[2] = ov2;
    ir_o[0] = ir0; ir_o[1] = ir1; ir_o[2] = ir2;
  end

  task automatic chk(string n, int i, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s[%0d]: got %h expected %h at %0t", n, i, act, exp, $time);
    end
  endtask

  // Reference: integer arithmetic on the mathematical values, range-checked for overflow.
  function automatic res_t model(int w, bit sg, logic [15:0] av, logic [15:0] bv, bit c, bit i);
    longint m  = (longint'(1) << w) - 1;
    longint h  = longint'(1) << (w - 1);
    longint ua = longint'(av) & m;
    longint ub = (i ? ~longint'(bv) : longint'(bv)) & m;
    longint u  = ua + ub + longint'(c);
    longint sa = ua >= h ? ua - 2 * h : ua;
    longint sv = ub >= h ? ub - 2 * h : ub;
    longint s  = sa + sv + longint'(c);
    res_t r;
    r.y   = 16'(u & m);
    r.x   = 16'(ua ^ ub);
    r.co  = 1'((u >> w) & 1);
    r.ovf = sg ? (s >= h || s < -h) : r.co;
`ifdef QLF_PIPE_ALU_SAT_EN
    if (r.ovf) r.y = 16'(sg ? (sa < 0 ? h : h - 1) : (i ? 0 : m));
`endif
    return r;
  endfunction

  always @(negedge clk) begin : mon
    res_t r, cur;
    if (reset_n) for (int i = 0; i < 3; i++) begin
      if (in_valid && ir_o[i]) sb[i].push_back(model(i == 2 ? 10 : 16, i == 1, a, b, ci, bi));
      cur.y = y_o[i]; cur.x = x_o[i]; cur.co = co_o[i]; cur.ovf = of_o[i];
      if (ov_o[i] && out_ready) begin
        delivered[i]++;
        if (sb[i].size() == 0) chk("unexpected_out", i, 1, 0);
        else begin
          r = sb[i].pop_front();
          chk("sb_y", i, cur.y, r.y);
          chk("sb_x", i, cur.x, r.x);
          chk("sb_co_ovf", i, {cur.co, cur.ovf}, {r.co, r.ovf});
        end
      end
      if (ov_o[i] && !out_ready) begin
        chk("stall_in_ready", i, ir_o[i], 0);
        if (held[i]) begin
          chk("hold_y", i, cur.y, hold_r[i].y);
          chk("hold_x", i, cur.x, hold_r[i].x);
          chk("hold_co_ovf", i, {cur.co, cur.ovf}, {hold_r[i].co, hold_r[i].ovf});
        end
        held[i] = 1;
        hold_r[i] = cur;
      end else held[i] = 0;
    end
  end

  task automatic send(logic [15:0] av, logic [15:0] bv, bit c, bit i);
    int n = 0;
    a = av; b = bv; ci = c; bi = i; in_valid = 1;
    @(negedge clk);
    while (!ir0 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("send_timeout", 0, 1, 0);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb[0].size() != 0 || sb[1].size() != 0 || sb[2].size() != 0) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_left", 0, sb[0].size() + sb[1].size() + sb[2].size(), 0);
  endtask

  task automatic run_vec(int i);
    int lat = 1, l0 = 0, l2 = 0;
    logic [15:0] cy0 = 0, cx0 = 0, cy1 = 0, cx1 = 0;
    logic [9:0]  cy2 = 0;
    logic cc0 = 0, cf0 = 0, cc1 = 0, cf1 = 0, cc2 = 0;
    send(vt[i].a, vt[i].b, vt[i].ci, vt[i].bi);
    while ((l0 == 0 || l2 == 0) && lat < 20) begin
      if (ov0 && l0 == 0) begin
        l0 = lat; cy0 = y0; cx0 = x0; cc0 = co0; cf0 = of0; cy1 = y1; cx1 = x1; cc1 = co1; cf1 = of1;
      end
      if (ov2 && l2 == 0) begin l2 = lat; cy2 = y2; cc2 = co2; end
      @(posedge clk); #1; lat++;
    end
    chk("lat_w16", i, l0, 4);
    chk("lat_w10", i, l2, 3);
    chk("vec_y_u", i, cy0, vt[i].yu);
    chk("vec_x_u", i, cx0, vt[i].x);
    chk("vec_co_u", i, cc0, vt[i].co);
    chk("vec_ovf_u", i, cf0, vt[i].co);
    chk("vec_y_s", i, cy1, vt[i].ys);
    chk("vec_x_s", i, cx1, vt[i].x);
    chk("vec_co_s", i, cc1, vt[i].co);
    chk("vec_ovf_s", i, cf1, vt[i].ovs);
    if (i == 6) begin
      chk("w10_y", i, cy2, 0);
      chk("w10_co", i, cc2, 1);
    end
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) begin sb[i].delete(); held[i] = 0; end
  endtask

  initial begin
    int d0, seen;
    vt[0] = '{16'h00FF, 16'h0001, 0, 0, 16'h0100, 16'h0100, 16'h00FE, 0, 0};
    vt[1] = '{16'h0005, 16'h0007, 1, 1, 16'hFFFE, 16'hFFFE, 16'hFFFD, 0, 0};
    vt[2] = '{16'h7FFF, 16'h0001, 0, 0, 16'h8000, 16'h8000, 16'h7FFE, 0, 1};
    vt[3] = '{16'hFFFF, 16'h0001, 0, 0, 16'h0000, 16'h0000, 16'hFFFE, 1, 0};
    vt[4] = '{16'h8000, 16'h0001, 1, 1, 16'h7FFF, 16'h7FFF, 16'h7FFE, 1, 1};
    vt[5] = '{16'h0FFF, 16'h0000, 1, 0, 16'h1000, 16'h1000, 16'h0FFF, 0, 0};
    vt[6] = '{16'h03FF, 16'h0001, 0, 0, 16'h0400, 16'h0400, 16'h03FE, 0, 0};
`ifdef QLF_PIPE_ALU_SAT_EN
    vt[2].ys = 16'h7FFF;
    vt[3].yu = 16'hFFFF;
    vt[4].yu = 16'h0000;
    vt[4].ys = 16'h8000;
`endif
    #2;
    chk("rst_out_valid", 0, ov0, 0);
    chk("rst_y", 0, y0, 0);
    chk("rst_x_co_ovf", 0, {x0, co0, of0}, 0);
    chk("rst_in_ready", 0, ir0, 1);
    @(negedge clk); @(negedge clk);
    reset_n = 1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 0, ir0, 1);
    for (int i = 0; i < 7; i++) run_vec(i);
    drain();
    // Ten back-to-back beats with a downstream stall in cycles 3-6.
    d0 = delivered[0];
    fork
      for (int k = 0; k < 10; k++) send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      begin
        for (int c = 0; c < 12; c++) begin out_ready = !(c >= 3 && c <= 6); @(posedge clk); #1; end
        out_ready = 1;
      end
    join
    drain();
    chk("stall_delivered", 0, delivered[0] - d0, 10);
    // Random traffic with random gaps and backpressure.
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        done = 1;
      end
      begin
        while (!done) begin out_ready = $urandom_range(0, 3) != 0; @(posedge clk); #1; end
        out_ready = 1;
      end
    join
    drain();
    // Reset while beats are in flight.
    for (int k = 0; k < 3; k++) send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    @(posedge clk); #1;
    chk("pre_rst_valid", 0, ov0, 1);
    reset_n = 0;
    flush();
    #1;
    chk("async_rst_valid", 0, {ov0, ov1, ov2}, 0);
    chk("async_rst_y", 0, y0, 0);
    chk("async_rst_x_co_ovf", 0, {x0, co0, of0}, 0);
    chk("async_rst_in_ready", 0, ir0, 1);
    repeat (2) @(negedge clk);
    reset_n = 1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin @(negedge clk); if (ov0 || ov1 || ov2) seen++; end
    chk("stale_after_rst", 0, seen, 0);
    chk("in_ready_after_rst", 0, ir0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
